// File: rtl/meta_action_align_pkg.sv
// rtl/meta_action_align_pkg.sv - shared widths, action classification and saturating increment
package meta_action_align_pkg;

    localparam int ACTION_LEN_DEF = 25;
    localparam int META_LEN_DEF   = 256;
    localparam int COMP_LEN_DEF   = 100;
    localparam int PHV_LEN_DEF    = META_LEN_DEF + COMP_LEN_DEF;
    localparam int SAT_MAX_W      = 32;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_POP,
        ACT_BYPASS,
        ACT_ORPHAN
    } act_kind_e;

    // Counters narrower than SAT_MAX_W are zero-extended by the caller; w is their real width.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned        w);
        logic [SAT_MAX_W-1:0] all_ones;
        all_ones = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (v >= all_ones) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/meta_fifo.sv
// rtl/meta_fifo.sv - in-order metadata buffer with combinational head and separate level count
module meta_fifo
    import meta_action_align_pkg::*;
#(
    parameter  int WIDTH = PHV_LEN_DEF,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en_i, rd_en_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // A write into the head slot while full is safe: the head is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/meta_action_align.sv
// rtl/meta_action_align.sv - buffers metadata and releases it coincident with its action word
module meta_action_align
    import meta_action_align_pkg::*;
#(
    parameter  int ACTION_LEN = ACTION_LEN_DEF,
    parameter  int META_LEN   = META_LEN_DEF,
    parameter  int COMP_LEN   = COMP_LEN_DEF,
    parameter  int DEPTH      = 8,
    parameter  int CNT_W      = 16,
    localparam int PHV_W      = META_LEN + COMP_LEN,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHV_W-1:0]      comp_meta_data_in,
    input  logic                  comp_meta_data_valid_in,
    output logic                  comp_meta_data_ready_out,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid_in,
    output logic [PHV_W-1:0]      comp_meta_data_out,
    output logic                  comp_meta_data_valid_out,
    output logic [ACTION_LEN-1:0] action_out,
    output logic                  action_valid_out,
    output logic [LVL_W-1:0]      fifo_level_out,
    output logic [CNT_W-1:0]      drop_cnt_out,
    output logic [CNT_W-1:0]      orphan_cnt_out
);

    logic [PHV_W-1:0]      head;
    logic [LVL_W-1:0]      level;
    logic                  full, empty;
    act_kind_e             act_kind;
    logic                  fifo_wr, fifo_rd, drop;

    logic [PHV_W-1:0]      meta_q, meta_d;
    logic [ACTION_LEN-1:0] action_q, action_d;
    logic                  valid_q, valid_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]      orphan_cnt_q, orphan_cnt_d;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    always_comb begin
        act_kind = ACT_NONE;
        if (action_valid_in) begin
            if (!empty)                       act_kind = ACT_POP;
            else if (comp_meta_data_valid_in) act_kind = ACT_BYPASS;
            else                              act_kind = ACT_ORPHAN;
        end
    end

    // A pop frees a slot this cycle, so a push at full still lands when paired with one.
    always_comb begin
        fifo_rd = (act_kind == ACT_POP);
        fifo_wr = comp_meta_data_valid_in && (act_kind != ACT_BYPASS) && (!full || fifo_rd);
        drop    = comp_meta_data_valid_in && full && !fifo_rd;
    end

    meta_fifo #(
        .WIDTH (PHV_W),
        .DEPTH (DEPTH)
    ) u_meta_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (comp_meta_data_in),
        .rd_en_i   (fifo_rd),
        .rd_data_o (head),
        .level_o   (level)
    );

    always_comb begin
        meta_d       = meta_q;
        action_d     = action_q;
        valid_d      = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        orphan_cnt_d = orphan_cnt_q;
        case (act_kind)
            ACT_POP: begin
                meta_d   = head;
                action_d = action_in;
                valid_d  = 1'b1;
            end
            ACT_BYPASS: begin
                meta_d   = comp_meta_data_in;
                action_d = action_in;
                valid_d  = 1'b1;
            end
            ACT_ORPHAN:
                orphan_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(orphan_cnt_q), unsigned'(CNT_W)));
            default: ;
        endcase
        if (drop) drop_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(drop_cnt_q), unsigned'(CNT_W)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q       <= '0;
            action_q     <= '0;
            valid_q      <= 1'b0;
            drop_cnt_q   <= '0;
            orphan_cnt_q <= '0;
        end else begin
            meta_q       <= meta_d;
            action_q     <= action_d;
            valid_q      <= valid_d;
            drop_cnt_q   <= drop_cnt_d;
            orphan_cnt_q <= orphan_cnt_d;
        end
    end

    assign comp_meta_data_ready_out = !full;
    assign comp_meta_data_out       = meta_q;
    assign comp_meta_data_valid_out = valid_q;
    assign action_out               = action_q;
    assign action_valid_out         = valid_q;
    assign fifo_level_out           = level;
    assign drop_cnt_out             = drop_cnt_q;
    assign orphan_cnt_out           = orphan_cnt_q;

endmodule

// File: tb/tb_meta_action_align.sv
// tb/tb_meta_action_align.sv - directed table, corner sequences and model-checked random traffic
module tb_meta_action_align;

    localparam int A_W   = 25;
    localparam int D_W   = 356;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int L_W   = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [D_W-1:0] cmd_in = '0;
    logic           cmd_vin = 1'b0;
    logic           rdy;
    logic [A_W-1:0] act_in = '0;
    logic           act_vin = 1'b0;
    logic [D_W-1:0] cmd_out;
    logic           cmd_vout;
    logic [A_W-1:0] act_out;
    logic           act_vout;
    logic [L_W-1:0] level;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] orph_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    meta_action_align #(
        .ACTION_LEN (A_W),
        .META_LEN   (256),
        .COMP_LEN   (100),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .comp_meta_data_in        (cmd_in),
        .comp_meta_data_valid_in  (cmd_vin),
        .comp_meta_data_ready_out (rdy),
        .action_in                (act_in),
        .action_valid_in          (act_vin),
        .comp_meta_data_out       (cmd_out),
        .comp_meta_data_valid_out (cmd_vout),
        .action_out               (act_out),
        .action_valid_out         (act_vout),
        .fifo_level_out           (level),
        .drop_cnt_out             (drop_cnt),
        .orphan_cnt_out           (orph_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           mv;
        logic [D_W-1:0] m;
        logic           av;
        logic [A_W-1:0] a;
        logic           ev;
        logic [D_W-1:0] em;
        logic [A_W-1:0] ea;
        logic [L_W-1:0] el;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic mv, logic [D_W-1:0] m, logic av, logic [A_W-1:0] a,
                                logic ev, logic [D_W-1:0] em, logic [A_W-1:0] ea, logic [L_W-1:0] el);
        vec_t v;
        v.mv = mv; v.m = m; v.av = av; v.a = a;
        v.ev = ev; v.em = em; v.ea = ea; v.el = el;
        return v;
    endfunction

    function automatic logic [D_W-1:0] rnd_meta();
        logic [D_W-1:0] r = '0;
        for (int i = 0; i < 12; i++) r = {r[D_W-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [D_W-1:0] got, input logic [D_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
    task automatic cyc(input logic mv, input logic [D_W-1:0] m, input logic av, input logic [A_W-1:0] a);
        cmd_vin = mv; cmd_in = m; act_vin = av; act_in = a;
        @(posedge clk);
        #1;
        cmd_vin = 1'b0; act_vin = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [D_W-1:0] vals [11];
    logic [D_W-1:0] mq [$];
    logic [D_W-1:0] em;
    logic [A_W-1:0] ea;
    logic           ev, mv, av;
    logic [D_W-1:0] m;
    logic [A_W-1:0] a;
    int             m_drop, m_orph, old_size;

    initial begin
        #1;
        chk("reset_valid", D_W'(cmd_vout), '0);
        chk("reset_avalid", D_W'(act_vout), '0);
        chk("reset_data", cmd_out, '0);
        chk("reset_action", D_W'(act_out), '0);
        chk("reset_level", D_W'(level), '0);
        chk("reset_drop", D_W'(drop_cnt), '0);
        chk("reset_orphan", D_W'(orph_cnt), '0);
        chk("reset_ready", D_W'(rdy), D_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // meta at T0, action at T3; then A,B,C in order; then same-cycle bypass
        tbl.push_back(mk(1, 356'h1, 0, '0,           0, '0, '0, 1));
        tbl.push_back(mk(0, '0, 0, '0,               0, '0, '0, 1));
        tbl.push_back(mk(0, '0, 0, '0,               0, '0, '0, 1));
        tbl.push_back(mk(0, '0, 1, 25'h1980000,      1, 356'h1, 25'h1980000, 0));
        tbl.push_back(mk(0, '0, 0, '0,               0, '0, '0, 0));
        tbl.push_back(mk(1, 356'hA, 0, '0,           0, '0, '0, 1));
        tbl.push_back(mk(1, 356'hB, 0, '0,           0, '0, '0, 2));
        tbl.push_back(mk(1, 356'hC, 0, '0,           0, '0, '0, 3));
        tbl.push_back(mk(0, '0, 1, 25'h11,           1, 356'hA, 25'h11, 2));
        tbl.push_back(mk(0, '0, 1, 25'h22,           1, 356'hB, 25'h22, 1));
        tbl.push_back(mk(0, '0, 1, 25'h33,           1, 356'hC, 25'h33, 0));
        tbl.push_back(mk(0, '0, 0, '0,               0, '0, '0, 0));
        tbl.push_back(mk(1, 356'hBEEF, 1, 25'h77,    1, 356'hBEEF, 25'h77, 0));
        tbl.push_back(mk(0, '0, 0, '0,               0, '0, '0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].mv, tbl[i].m, tbl[i].av, tbl[i].a);
            chk($sformatf("tbl%0d_valid", i), D_W'(cmd_vout), D_W'(tbl[i].ev));
            chk($sformatf("tbl%0d_avalid", i), D_W'(act_vout), D_W'(tbl[i].ev));
            chk($sformatf("tbl%0d_level", i), D_W'(level), D_W'(tbl[i].el));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_meta", i), cmd_out, tbl[i].em);
                chk($sformatf("tbl%0d_action", i), D_W'(act_out), D_W'(tbl[i].ea));
            end
        end
        chk("tbl_drop", D_W'(drop_cnt), '0);
        chk("tbl_orphan", D_W'(orph_cnt), '0);

        // overflow: 10 pushes, 2 dropped, then push+pop at full, then drain
        for (int i = 0; i < 11; i++) vals[i] = D_W'(i + 100);
        for (int i = 0; i < 10; i++) begin
            cyc(1, vals[i], 0, '0);
            if (i == 7) begin
                chk("ovf_ready_at_8", D_W'(rdy), '0);
                chk("ovf_level_at_8", D_W'(level), D_W'(8));
            end
        end
        chk("ovf_drop", D_W'(drop_cnt), D_W'(2));
        chk("ovf_level", D_W'(level), D_W'(8));
        cyc(1, vals[10], 1, 25'h100);
        chk("full_pushpop_meta", cmd_out, vals[0]);
        chk("full_pushpop_level", D_W'(level), D_W'(8));
        chk("full_pushpop_drop", D_W'(drop_cnt), D_W'(2));
        for (int i = 1; i < 9; i++) begin
            cyc(0, '0, 1, A_W'(i));
            chk($sformatf("drain%0d_valid", i), D_W'(cmd_vout), D_W'(1));
            chk($sformatf("drain%0d_meta", i), cmd_out, (i < 8) ? vals[i] : vals[10]);
            chk($sformatf("drain%0d_level", i), D_W'(level), D_W'(8 - i));
        end
        cyc(0, '0, 0, '0);
        chk("drain_idle_valid", D_W'(cmd_vout), '0);

        // orphans and saturation
        cyc(0, '0, 1, 25'h5);
        chk("orphan_valid", D_W'(cmd_vout), '0);
        chk("orphan_cnt1", D_W'(orph_cnt), D_W'(1));
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc(0, '0, 1, 25'h5);
        chk("orphan_sat", D_W'(orph_cnt), D_W'(MAXC));
        chk("orphan_sat_valid", D_W'(act_vout), '0);

        // reset mid-stream with a valid output and level 4
        for (int i = 0; i < 5; i++) cyc(1, vals[i], 0, '0);
        cyc(0, '0, 1, 25'h9);
        chk("pre_rst_valid", D_W'(cmd_vout), D_W'(1));
        chk("pre_rst_level", D_W'(level), D_W'(4));
        rst = 1'b1;
        #1;
        chk("async_rst_valid", D_W'(cmd_vout), '0);
        chk("async_rst_avalid", D_W'(act_vout), '0);
        chk("async_rst_level", D_W'(level), '0);
        chk("async_rst_orphan", D_W'(orph_cnt), '0);
        chk("async_rst_ready", D_W'(rdy), D_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, '0, 1, 25'h3);
        chk("post_rst_valid", D_W'(cmd_vout), '0);
        chk("post_rst_orphan", D_W'(orph_cnt), D_W'(1));
        chk("post_rst_level", D_W'(level), '0);

        // random traffic against a queue model
        do_reset();
        mq = {};
        m_drop = 0;
        m_orph = 0;
        for (int c = 0; c < 600; c++) begin
            mv = ($urandom_range(0, 99) < 55);
            av = ($urandom_range(0, 99) < 45);
            m  = rnd_meta();
            a  = A_W'($urandom);
            old_size = mq.size();
            ev = 1'b0;
            em = '0;
            ea = '0;
            if (av) begin
                if (old_size > 0) begin
                    ev = 1'b1; em = mq.pop_front(); ea = a;
                end else if (mv) begin
                    ev = 1'b1; em = m; ea = a;
                end else if (m_orph < MAXC) begin
                    m_orph++;
                end
            end
            if (mv && !(av && old_size == 0)) begin
                if (old_size < DEPTH || (av && old_size > 0)) mq.push_back(m);
                else if (m_drop < MAXC) m_drop++;
            end
            cyc(mv, m, av, a);
            chk($sformatf("rnd%0d_valid", c), D_W'(cmd_vout), D_W'(ev));
            chk($sformatf("rnd%0d_avalid", c), D_W'(act_vout), D_W'(ev));
            if (ev) begin
                chk($sformatf("rnd%0d_meta", c), cmd_out, em);
                chk($sformatf("rnd%0d_action", c), D_W'(act_out), D_W'(ea));
            end
            chk($sformatf("rnd%0d_level", c), D_W'(level), D_W'(mq.size()));
            chk($sformatf("rnd%0d_ready", c), D_W'(rdy), D_W'(mq.size() != DEPTH));
            chk($sformatf("rnd%0d_drop", c), D_W'(drop_cnt), D_W'(m_drop));
            chk($sformatf("rnd%0d_orphan", c), D_W'(orph_cnt), D_W'(m_orph));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
